mchan_rr_arb_slice_ipa: RTL
===========================

MCHAN_RR_ARB_SLICE_IPA -- requirements
Module: mchan_rr_arb_slice_ipa

Interface
REQ-001 Parameter N_IN, default 4: number of requesters; power of two, 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: payload width per requester.
REQ-003 Parameter ID_WIDTH, default $clog2(N_IN): width of the winner index.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_i  input  N_IN  per-requester request.
REQ-007 data_i  input  N_IN x DATA_WIDTH  per-requester payload, valid while req_i set.
REQ-008 gnt_o  output  N_IN  one-hot grant; at most one bit set per cycle.
REQ-009 req_o  output  1  registered request toward the downstream consumer.
REQ-010 data_o  output  DATA_WIDTH  registered payload of the current winner.
REQ-011 id_o  output  ID_WIDTH  index of the requester whose payload is in data_o.
REQ-012 gnt_i  input  1  downstream acceptance; transfer occurs when req_o & gnt_i.

Function
REQ-013 Internal round-robin pointer ptr (ID_WIDTH bits) SHALL give highest priority to index ptr, then ptr+1, ..., wrapping at N_IN-1 to 0.
REQ-014 Slice is "free" when req_o = 0 or (req_o & gnt_i); arbitration SHALL occur only in a free cycle.
REQ-015 In a free cycle with any req_i set, gnt_o SHALL be one-hot on the first set req_i at or after ptr (combinational, same cycle).
REQ-016 In a non-free cycle (req_o & !gnt_i), gnt_o SHALL be all-zero regardless of req_i.
REQ-017 On a grant to index w, next edge SHALL load data_o <= data_i[w], id_o <= w, req_o <= 1, ptr <= (w+1) mod N_IN.
REQ-018 In a free cycle with no req_i set, req_o SHALL go to 0 next edge; ptr, data_o, id_o SHALL hold.
REQ-019 While req_o & !gnt_i, req_o, data_o and id_o SHALL remain stable.
REQ-020 Latency: grant cycle to req_o = 1 is exactly one clock; sustained throughput one transfer per cycle when gnt_i held high.
REQ-021 Simultaneous drain and fill (req_o & gnt_i with a new grant) SHALL replace the slice contents with no bubble.
REQ-022 ptr SHALL update only on a grant; idle cycles SHALL not advance it.
REQ-023 Requesters SHALL hold req_i and data_i until gnt_o; a request dropped before grant is legal and simply not considered.
REQ-024 ptr wrap: grant to index N_IN-1 SHALL set ptr to 0.

Reset
REQ-025 On rst_n low, asynchronously: req_o = 0, data_o = 0, id_o = 0, ptr = 0; gnt_o = 0 while in reset.
REQ-026 Reset mid-transfer SHALL discard the held payload; first grant after release goes to lowest set index >= 0.

Structure
REQ-027 Shared package mchan_pkg SHALL hold the default N_IN/DATA_WIDTH constants and a one-hot-to-index function.
REQ-028 Priority selection SHALL live in one combinational sub-module mchan_rr_pick_ipa (inputs req vector, ptr; outputs one-hot and index, valid).
REQ-029 Top level holds ptr, output register and free logic only; no latches, no combinational path from gnt_i to req_o.

Verification (N_IN = 4, DATA_WIDTH = 32)
REQ-030 Reset release, req_i = 4'b0000 for 5 cycles -> req_o = 0, gnt_o = 0, ptr stays 0.
REQ-031 req_i = 4'b1111 constant, gnt_i = 1, data_i[k] = 0xA0+k -> gnt_o cycles 0001,0010,0100,1000,0001; id_o 0,1,2,3,0 one cycle later; data_o 0xA0..0xA3.
REQ-032 req_o = 1, id_o = 2, gnt_i = 0 for 3 cycles with req_i = 4'b0011 -> gnt_o = 0, data_o/id_o unchanged; gnt_i = 1 then -> gnt_o = 0001 (ptr = 3 wraps to 0).
REQ-033 Only req_i[3] set, gnt_i = 1 for 4 cycles -> gnt_o = 1000 every cycle, req_o continuously 1, no bubbles.
REQ-034 Alternate gnt_i 1/0 with req_i = 4'b0101 -> grants alternate 0 and 2, one grant per accepted transfer, no payload lost or duplicated (scoreboard).
REQ-035 Assert rst_n low while req_o = 1, id_o = 1 -> req_o, id_o, data_o = 0 immediately; after release with req_i = 4'b0110 first grant = 0010.

Source files
------------

// File: rtl/mchan_pkg.sv
// Shared constants and helpers for the multi-channel round-robin arbiter slice.
package mchan_pkg;

    localparam int unsigned MCHAN_N_IN       = 4;
    localparam int unsigned MCHAN_DATA_WIDTH = 32;
    localparam int unsigned MCHAN_MAX_N      = 16;
    localparam int unsigned MCHAN_MAX_ID_W   = 4;

    // OR-reduction of set bit positions; exact for a one-hot (or all-zero) input.
    function automatic logic [MCHAN_MAX_ID_W-1:0] onehot_to_idx(input logic [MCHAN_MAX_N-1:0] oh);
        logic [MCHAN_MAX_ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MCHAN_MAX_N; i++) begin
            if (oh[i]) idx = idx | MCHAN_MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mchan_rr_pick_ipa.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module mchan_rr_pick_ipa
    import mchan_pkg::*;
#(
    parameter int unsigned N_IN     = MCHAN_N_IN,
    parameter int unsigned ID_WIDTH = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]     req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_IN-1:0]     onehot,
    output logic [ID_WIDTH-1:0] idx,
    output logic                valid
);

    logic                   found;
    logic [ID_WIDTH-1:0]    pos;
    logic [MCHAN_MAX_N-1:0] oh_ext;

    // N_IN is a power of two, so ptr + i wraps naturally in ID_WIDTH bits.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            pos = ptr + ID_WIDTH'(i);
            if (!found && req[pos]) begin
                onehot[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign oh_ext = MCHAN_MAX_N'(onehot);
    assign idx    = ID_WIDTH'(onehot_to_idx(oh_ext));
    assign valid  = |req;

endmodule

// File: rtl/mchan_rr_arb_slice_ipa.sv
// Round-robin arbiter feeding a single registered output slice with stall support.
module mchan_rr_arb_slice_ipa
    import mchan_pkg::*;
#(
    parameter int unsigned N_IN       = MCHAN_N_IN,
    parameter int unsigned DATA_WIDTH = MCHAN_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = $clog2(N_IN)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_IN-1:0]                  req_i,
    input  logic [N_IN-1:0][DATA_WIDTH-1:0]  data_i,
    output logic [N_IN-1:0]                  gnt_o,
    output logic                             req_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic [ID_WIDTH-1:0]              id_o,
    input  logic                             gnt_i
);

    logic [ID_WIDTH-1:0] ptr;
    logic [N_IN-1:0]     pick_onehot;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_valid;
    logic                free;

    mchan_rr_pick_ipa #(
        .N_IN     (N_IN),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Slice can accept new contents when empty or being drained this cycle.
    assign free  = !req_o || gnt_i;
    assign gnt_o = (rst_n && free) ? pick_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_o  <= 1'b0;
            data_o <= '0;
            id_o   <= '0;
            ptr    <= '0;
        end else if (free) begin
            if (pick_valid) begin
                req_o  <= 1'b1;
                data_o <= data_i[pick_idx];
                id_o   <= pick_idx;
                ptr    <= pick_idx + ID_WIDTH'(1);
            end else begin
                req_o  <= 1'b0;
            end
        end
    end

endmodule
